// File: rtl/mfp_adc_max10_model_pkg.sv
// Purpose: shared types and constants for the MAX10 ADC sequencer model.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mfp_adc_max10_model_pkg;

    localparam int CH_W   = 5;
    localparam int DATA_W = 12;
    localparam int CNT_W  = 8;

    // Channel codes shared with the ADC core header
    localparam logic [CH_W-1:0] ADC_CH_0    = 5'd0;
    localparam logic [CH_W-1:0] ADC_CH_TSD  = 5'd17;
    localparam logic [CH_W-1:0] ADC_CH_NONE = 5'h1F;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_CONV = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Command fields captured at accept and echoed on the response
    typedef struct packed {
        logic [CH_W-1:0] channel;
        logic            sop;
        logic            eop;
    } cmd_t;

endpackage

// File: rtl/adc_model_pkt_check.sv
// Purpose: tracks command packet framing and raises a sticky framing error.
// Latency: cmd_error updates on the edge that accepts the offending beat.
// Backpressure: none; observes accepted beats only.
module adc_model_pkt_check (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    input  logic sop,
    input  logic eop,
    input  logic err_clear,
    output logic cmd_error
);

    logic in_packet_q, in_packet_d;
    logic cmd_error_q, cmd_error_d;
    logic frame_err;

    // Framing rule: SOP must open a packet and never appear inside one; set beats clear
    always_comb begin
        frame_err   = 1'b0;
        in_packet_d = in_packet_q;
        if (accept) begin
            frame_err   = sop ? in_packet_q : ~in_packet_q;
            in_packet_d = (in_packet_q | sop) & ~eop;
        end
        // A new error takes priority over a simultaneous clear
        cmd_error_d = frame_err | (cmd_error_q & ~err_clear);
    end

    // Packet state and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_packet_q <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            in_packet_q <= in_packet_d;
            cmd_error_q <= cmd_error_d;
        end
    end

    assign cmd_error = cmd_error_q;

endmodule

// File: rtl/mfp_adc_max10_model.sv
// Purpose: behavioural MAX10 ADC sequencer, responder end of the command/response stream pair.
// Latency: accept at edge N -> ADC_R_Valid pulse after edge N+CONV_CYCLES+1; optional Ready stalls via MFP_ADC_MODEL_STALL_EN.
// Backpressure: one command in flight; Ready low outside S_IDLE; responses cannot be stalled.
module mfp_adc_max10_model
    import mfp_adc_max10_model_pkg::*;
#(
    parameter int         CONV_CYCLES = 4,
    parameter logic [3:0] STALL_SEED  = 4'b1001
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              ADC_C_Valid,
    input  logic [CH_W-1:0]   ADC_C_Channel,
    input  logic              ADC_C_SOP,
    input  logic              ADC_C_EOP,
    output logic              ADC_C_Ready,
    output logic              ADC_R_Valid,
    output logic [CH_W-1:0]   ADC_R_Channel,
    output logic [DATA_W-1:0] ADC_R_Data,
    output logic              ADC_R_SOP,
    output logic              ADC_R_EOP,
    input  logic              err_clear,
    output logic              cmd_error,
    output logic [CNT_W-1:0]  conv_count
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   conv_count_q, conv_count_d;
    cmd_t               cmd_q, cmd_d;
    logic               r_vld_q, r_vld_d;
    cmd_t               r_cmd_q, r_cmd_d;
    logic [DATA_W-1:0]  r_data_q, r_data_d;
    logic               ready;
    logic               accept;

`ifdef MFP_ADC_MODEL_STALL_EN
    logic [3:0] lfsr_q, lfsr_d;

    // Free-running x^4+x^3+1 Fibonacci LFSR used to randomise Ready
    always_comb begin
        lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end

    // LFSR register, seeded on reset
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) lfsr_q <= STALL_SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign ready = (state_q == S_IDLE) & ~lfsr_q[0];
`else
    logic stall_seed_unused;
    assign stall_seed_unused = ^STALL_SEED;
    assign ready = (state_q == S_IDLE);
`endif

    assign accept = ADC_C_Valid & ready;

    // Sequencer next state: accept, count down the conversion, emit one response beat
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        conv_count_d = conv_count_q;
        r_vld_d      = 1'b0;
        r_cmd_d      = r_cmd_q;
        r_data_d     = r_data_q;
        case (state_q)
            S_INIT: state_d = S_IDLE;
            S_IDLE: begin
                if (accept) begin
                    cmd_d   = '{channel: ADC_C_Channel, sop: ADC_C_SOP, eop: ADC_C_EOP};
                    cnt_d   = CNT_W'(CONV_CYCLES - 1);
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RESP: begin
                r_vld_d      = 1'b1;
                r_cmd_d      = cmd_q;
                r_data_d     = {cmd_q.channel[3:0], conv_count_q};
                conv_count_d = conv_count_q + 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Sequencer and response registers; response fields hold between pulses
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            cmd_q        <= '0;
            conv_count_q <= '0;
            r_vld_q      <= 1'b0;
            r_cmd_q      <= '0;
            r_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            conv_count_q <= conv_count_d;
            r_vld_q      <= r_vld_d;
            r_cmd_q      <= r_cmd_d;
            r_data_q     <= r_data_d;
        end
    end

    adc_model_pkt_check u_pkt_check (
        .clk       (CLK),
        .rst_n     (RESETn),
        .accept    (accept),
        .sop       (ADC_C_SOP),
        .eop       (ADC_C_EOP),
        .err_clear (err_clear),
        .cmd_error (cmd_error)
    );

    assign ADC_C_Ready   = ready;
    assign ADC_R_Valid   = r_vld_q;
    assign ADC_R_Channel = r_cmd_q.channel;
    assign ADC_R_SOP     = r_cmd_q.sop;
    assign ADC_R_EOP     = r_cmd_q.eop;
    assign ADC_R_Data    = r_data_q;
    assign conv_count    = conv_count_q;

endmodule

// File: doc/mfp_adc_max10_model.md
Name: mfp_adc_max10_model

Overview:
Synthesizable behavioural model of the MAX10 ADC hard-IP sequencer. It is the responder end of the ADC command/response Avalon-ST pair.
- Accepts command beats: Valid, Channel, SOP, EOP, answered by Ready.
- Performs one "conversion" per command, with a fixed latency.
- Returns one response beat per command: Valid, Channel, Data, SOP, EOP.
- Used in simulation and in FPGA builds without ADC hard IP, so the ADC core and its AHB-Lite wrapper can be exercised end to end.

Parameters:
- CONV_CYCLES, 4, number of cycles in S_CONV per conversion; legal range 1..255.
- STALL_SEED, 4'b1001, nonzero LFSR seed; used only with MFP_ADC_MODEL_STALL_EN.

Ports:
- CLK  in  1  clock.
- RESETn  in  1  asynchronous active-low reset.
- ADC_C_Valid  in  1  command beat valid.
- ADC_C_Channel  in  5  command channel code.
- ADC_C_SOP  in  1  command start of packet.
- ADC_C_EOP  in  1  command end of packet.
- ADC_C_Ready  out  1  model accepts command this cycle.
- ADC_R_Valid  out  1  response beat valid, one-cycle pulse.
- ADC_R_Channel  out  5  echoed channel code.
- ADC_R_Data  out  12  conversion result.
- ADC_R_SOP  out  1  echoed SOP.
- ADC_R_EOP  out  1  echoed EOP.
- err_clear  in  1  clears cmd_error.
- cmd_error  out  1  sticky packet-framing error flag.
- conv_count  out  8  completed conversion counter.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - State = S_INIT; counter = 0; conv_count = 0; in_packet = 0; cmd_error = 0.
  - Latched channel/SOP/EOP = 0.
  - All outputs 0; ADC_C_Ready = 0.
- Reset mid-conversion abandons the command with no response beat.
- States, all transitions on the CLK rising edge:
  - S_INIT: Ready = 0. Goes to S_IDLE unconditionally after one cycle.
  - S_IDLE: Ready = 1. On ADC_C_Valid & Ready, latch Channel/SOP/EOP, load counter = CONV_CYCLES-1, go to S_CONV. Otherwise stay.
  - S_CONV: Ready = 0. Decrement counter; when counter == 0, go to S_RESP.
  - S_RESP: ADC_R_Valid = 1 for exactly one cycle. R_Channel/R_SOP/R_EOP = latched values; R_Data = {latched_channel[3:0], conv_count}. conv_count increments at the end of this cycle (255 wraps to 0). Always returns to S_IDLE; there is no response backpressure.
- Latency: command accepted at edge N gives ADC_R_Valid high in the cycle after edge N+CONV_CYCLES+1.
- Minimum command-to-command spacing is CONV_CYCLES+2 cycles.
- ADC_R_* other than Valid hold their last values while Valid = 0. After reset they are 0.
- Any 5-bit channel code is accepted and echoed, including the all-ones "none" code. No channel validity check.
- Packet checker, evaluated on every accepted command:
  - Error if SOP=1 while in_packet=1 (SOP inside a packet).
  - Error if SOP=0 while in_packet=0 (missing SOP).
  - in_packet next = (in_packet | SOP) & ~EOP.
  - An erroring beat is still converted normally.
  - cmd_error sets on error and holds until err_clear=1 or reset. Simultaneous error and err_clear: set wins.
- ADC_C_Valid without Ready is ignored; the master must hold the beat.

Optional Feature:
- Macro MFP_ADC_MODEL_STALL_EN.
- When defined: a 4-bit Fibonacci LFSR (taps 4,3; seeded STALL_SEED at reset) advances every cycle. In S_IDLE, Ready = ~lfsr[0]. This exercises the initiator's wait-on-Ready path. Latency is counted from the actual accept edge.
- When undefined: no LFSR; Ready = (State == S_IDLE).

Decomposition:
- Shared package mfp_adc_max10_model.vh holds:
  - State encodings (S_INIT, S_IDLE, S_CONV, S_RESP).
  - Data and channel widths.
  - Channel codes matching the ADC core header.
- One sub-module, adc_model_pkt_check: holds in_packet and the cmd_error sticky logic.
  - Inputs: accept, SOP, EOP, err_clear.
  - Output: cmd_error.

Test Plan:
- Reset release → Ready=0 one cycle, then 1. Single beat ch=5'h01 SOP=EOP=1 accepted at edge N → R_Valid cycle N+6 (CONV_CYCLES=4), R_Channel=1, R_Data=12'h100, SOP=EOP=1. conv_count then 1.
- Three-beat packet ch 0,2,17 with SOP on first and EOP on last → three responses in order:
  - Data 12'h001, 12'h202, 12'h103.
  - SOP only on the first response, EOP only on the last.
  - cmd_error=0.
- Beat with SOP=0 after idle → cmd_error=1. Still converted. err_clear pulse → 0. Error and clear in same cycle → stays 1.
- 256 conversions → conv_count wraps to 0; 257th response low byte = 8'h00.
- Assert RESETn low during S_CONV → outputs 0 immediately, no R_Valid pulse. Next command after recovery returns conv_count-based data starting at 0.
- With MFP_ADC_MODEL_STALL_EN: Valid held 20 cycles → accept only when Ready=1, exactly one response per command, latency measured from the accept edge.
